// File: rtl/varint_pkg.sv
// Shared types and helpers for the varint field arbiter.
package varint_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_KEY  = 2'd1,
      ST_VAL  = 2'd2
   } arb_state_t;

   localparam logic [2:0] WIRE_VARINT = 3'd0;

   // sint32 mapping: small magnitudes of either sign become small unsigned values
   function automatic logic [31:0] zigzag32(input logic [31:0] d);
      return (d << 1) ^ {32{d[31]}};
   endfunction

endpackage

// File: rtl/varint_field_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_valid,
   output logic [IDX_W-1:0]   o_idx
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_idx;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_sum   = '0;
      w_idx   = '0;
      // scan farthest to nearest so the nearest set slot is the last to win
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NUM_REQ))
            w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
         w_idx = w_sum[IDX_W-1:0];
         if (i_req[w_idx]) begin
            o_valid = 1'b1;
            o_idx   = w_idx;
         end
      end
   end

endmodule

// File: rtl/varint_field_arbiter.sv
// Shares one varint encoder among NUM_REQ field producers: pushes key then value per grant.
// Optional sint32 zigzag on the value is enabled by defining VARINT_ARB_ZIGZAG_EN.
//
// state   | meaning
// IDLE    | no field in progress, arbitrate among non-empty requesters
// KEY     | key word latched, pushing it when the encoder FIFO has room
// VAL     | value word latched, pushing it and popping the requester
module varint_field_arbiter
   import varint_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int FIELD_W = 5,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_empty,
   input  logic [NUM_REQ*32-1:0]      req_data,
   input  logic [NUM_REQ*FIELD_W-1:0] req_field,
   input  logic [NUM_REQ-1:0]         req_signed,
   output logic [NUM_REQ-1:0]         req_pop,
   input  logic                       enc_fifo_full,
   output logic                       enc_push,
   output logic [31:0]                enc_data,
   output logic                       enc_is_key,
   output logic [IDX_W-1:0]           enc_src
);

   arb_state_t       r_state;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] r_grant;
   logic [31:0]      r_key;
   logic [31:0]      r_val;

   logic               w_valid;
   logic [IDX_W-1:0]   w_pick;
   logic [31:0]        w_pick_data;
   logic [31:0]        w_pick_val;
   logic [FIELD_W-1:0] w_pick_field;

   rr_pick #(
      .NUM_REQ(NUM_REQ),
      .IDX_W  (IDX_W)
   ) u_rr_pick (
      .i_req  (~req_empty),
      .i_ptr  (r_rr_ptr),
      .o_valid(w_valid),
      .o_idx  (w_pick)
   );

   assign w_pick_data  = req_data[int'(w_pick)*32 +: 32];
   assign w_pick_field = req_field[int'(w_pick)*FIELD_W +: FIELD_W];

`ifdef VARINT_ARB_ZIGZAG_EN
   assign w_pick_val = req_signed[w_pick] ? zigzag32(w_pick_data) : w_pick_data;
`else
   logic w_unused_signed;
   assign w_unused_signed = ^req_signed;
   assign w_pick_val      = w_pick_data;
`endif

   assign enc_push   = (r_state != ST_IDLE) && !enc_fifo_full;
   assign enc_is_key = (r_state == ST_KEY) && !enc_fifo_full;
   assign enc_data   = (r_state == ST_VAL) ? r_val : r_key;
   assign enc_src    = r_grant;

   always_comb begin
      req_pop = '0;
      if (r_state == ST_VAL && !enc_fifo_full)
         req_pop[r_grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_grant  <= '0;
         r_key    <= '0;
         r_val    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_grant <= w_pick;
                  r_key   <= 32'({w_pick_field, WIRE_VARINT});
                  r_val   <= w_pick_val;
                  r_state <= ST_KEY;
               end
            end
            ST_KEY: begin
               if (!enc_fifo_full)
                  r_state <= ST_VAL;
            end
            ST_VAL: begin
               if (!enc_fifo_full) begin
                  r_rr_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_varint_field_arbiter.sv
// Self-checking bench for varint_field_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of requester FIFOs and round-robin order.
module tb_varint_field_arbiter;

   localparam int NUM_REQ = 4;
   localparam int FIELD_W = 5;
   localparam int IDX_W   = 2;

`ifdef VARINT_ARB_ZIGZAG_EN
   localparam bit ZZ = 1'b1;
`else
   localparam bit ZZ = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       reset;
   logic [NUM_REQ-1:0]         req_empty;
   logic [NUM_REQ*32-1:0]      req_data;
   logic [NUM_REQ*FIELD_W-1:0] req_field;
   logic [NUM_REQ-1:0]         req_signed;
   logic [NUM_REQ-1:0]         req_pop;
   logic                       enc_fifo_full;
   logic                       enc_push;
   logic [31:0]                enc_data;
   logic                       enc_is_key;
   logic [IDX_W-1:0]           enc_src;

   int total = 0;
   int bad   = 0;

   logic [31:0]        q[NUM_REQ][$];
   logic [FIELD_W-1:0] fld[NUM_REQ];
   logic               sgn[NUM_REQ];

   varint_field_arbiter #(.NUM_REQ(NUM_REQ), .FIELD_W(FIELD_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_empty    (req_empty),
      .req_data     (req_data),
      .req_field    (req_field),
      .req_signed   (req_signed),
      .req_pop      (req_pop),
      .enc_fifo_full(enc_fifo_full),
      .enc_push     (enc_push),
      .enc_data     (enc_data),
      .enc_is_key   (enc_is_key),
      .enc_src      (enc_src)
   );

   always #5 clk = ~clk;

   // sint32 zigzag from its arithmetic definition: n>=0 -> 2n, n<0 -> -2n-1
   function automatic logic [31:0] model_value(input logic [31:0] d, input logic s);
      longint n;
      if (ZZ && s) begin
         n = longint'(signed'(d));
         n = (n >= 0) ? 2 * n : -2 * n - 1;
         return n[31:0];
      end
      return d;
   endfunction

   function automatic int model_pick(input int ptr);
      for (int k = 0; k < NUM_REQ; k++)
         if (q[(ptr + k) % NUM_REQ].size() != 0) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_empty[i]                     = (q[i].size() == 0);
         req_data[32*i +: 32]             = (q[i].size() != 0) ? q[i][0] : $urandom;
         req_field[FIELD_W*i +: FIELD_W]  = fld[i];
         req_signed[i]                    = sgn[i];
      end
   endtask

   task automatic apply_reset();
      reset         = 1'b0;
      enc_fifo_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         q[i].delete();
         fld[i] = '0;
         sgn[i] = 1'b0;
      end
      drive_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      total++; if (req_pop !== '0) begin bad++; $display("FAIL reset_req_pop got=%h exp=0", req_pop); end
      total++; if (enc_push !== 1'b0) begin bad++; $display("FAIL reset_enc_push got=%b exp=0", enc_push); end
      total++; if (enc_data !== 32'h0) begin bad++; $display("FAIL reset_enc_data got=%h exp=0", enc_data); end
      total++; if (enc_is_key !== 1'b0) begin bad++; $display("FAIL reset_enc_is_key got=%b exp=0", enc_is_key); end
      total++; if (enc_src !== '0) begin bad++; $display("FAIL reset_enc_src got=%0d exp=0", enc_src); end
   endtask

   task automatic test_single();
      apply_reset();
      fld[0] = 5'd1;
      q[0].push_back(32'h0000_0096);
      drive_inputs();
      @(negedge clk);
      total++; if (enc_push !== 1'b0) begin bad++; $display("FAIL single_idle_push got=%b exp=0", enc_push); end
      @(negedge clk);
      total++; if (enc_push !== 1'b1 || enc_is_key !== 1'b1 || enc_data !== 32'h8)
         begin bad++; $display("FAIL single_key got push=%b key=%b data=%h exp push=1 key=1 data=00000008", enc_push, enc_is_key, enc_data); end
      total++; if (req_pop !== 4'b0000) begin bad++; $display("FAIL single_key_pop got=%b exp=0000", req_pop); end
      @(negedge clk);
      total++; if (enc_push !== 1'b1 || enc_is_key !== 1'b0 || enc_data !== 32'h96)
         begin bad++; $display("FAIL single_val got push=%b key=%b data=%h exp push=1 key=0 data=00000096", enc_push, enc_is_key, enc_data); end
      total++; if (req_pop !== 4'b0001) begin bad++; $display("FAIL single_val_pop got=%b exp=0001", req_pop); end
      @(posedge clk); #1;
      void'(q[0].pop_front());
      drive_inputs();
      @(negedge clk);
      total++; if (enc_push !== 1'b0 || req_pop !== '0)
         begin bad++; $display("FAIL single_after got push=%b pop=%b exp push=0 pop=0", enc_push, req_pop); end
   endtask

   task automatic test_stall();
      apply_reset();
      fld[2] = 5'd3;
      q[2].push_back(32'h0000_0081);
      drive_inputs();
      @(posedge clk); #1;
      enc_fifo_full = 1'b1;
      req_data[64 +: 32] = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++; if (enc_push !== 1'b0 || req_pop !== '0 || enc_is_key !== 1'b0)
            begin bad++; $display("FAIL stall_quiet c=%0d got push=%b pop=%b key=%b exp all 0", c, enc_push, req_pop, enc_is_key); end
         total++; if (enc_src !== 2'd2) begin bad++; $display("FAIL stall_src got=%0d exp=2", enc_src); end
         @(posedge clk); #1;
      end
      enc_fifo_full = 1'b0;
      @(negedge clk);
      total++; if (enc_push !== 1'b1 || enc_is_key !== 1'b1 || enc_data !== 32'h18)
         begin bad++; $display("FAIL stall_key got push=%b key=%b data=%h exp push=1 key=1 data=00000018", enc_push, enc_is_key, enc_data); end
      @(negedge clk);
      total++; if (enc_push !== 1'b1 || enc_data !== 32'h81 || req_pop !== 4'b0100)
         begin bad++; $display("FAIL stall_val got push=%b data=%h pop=%b exp push=1 data=00000081 pop=0100", enc_push, enc_data, req_pop); end
      @(posedge clk); #1;
      void'(q[2].pop_front());
      drive_inputs();
   endtask

   task automatic test_zigzag();
      logic [31:0] din[3];
      logic [31:0] dexp[3];
      din[0] = 32'hFFFF_FFFF; dexp[0] = ZZ ? 32'h0000_0001 : 32'hFFFF_FFFF;
      din[1] = 32'h0000_0005; dexp[1] = ZZ ? 32'h0000_000A : 32'h0000_0005;
      din[2] = 32'h8000_0000; dexp[2] = ZZ ? 32'hFFFF_FFFF : 32'h8000_0000;
      apply_reset();
      fld[1] = 5'd5;
      sgn[1] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         q[1].push_back(din[t]);
         drive_inputs();
         @(negedge clk);
         @(negedge clk);
         total++; if (enc_is_key !== 1'b1 || enc_data !== 32'h28)
            begin bad++; $display("FAIL zz_key t=%0d got key=%b data=%h exp key=1 data=00000028", t, enc_is_key, enc_data); end
         @(negedge clk);
         total++; if (enc_push !== 1'b1 || enc_data !== dexp[t] || req_pop !== 4'b0010)
            begin bad++; $display("FAIL zz_val t=%0d got push=%b data=%h pop=%b exp data=%h pop=0010", t, enc_push, enc_data, req_pop, dexp[t]); end
         @(posedge clk); #1;
         void'(q[1].pop_front());
         drive_inputs();
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      fld[3] = 5'd7;
      q[3].push_back(32'h1234_5678);
      drive_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      enc_fifo_full = 1'b1;
      @(negedge clk);
      total++; if (enc_push !== 1'b0 || req_pop !== '0)
         begin bad++; $display("FAIL rmid_stall got push=%b pop=%b exp 0 0", enc_push, req_pop); end
      #1 reset = 1'b0;
      #1;
      total++; if (req_pop !== '0 || enc_push !== 1'b0 || enc_data !== 32'h0 || enc_is_key !== 1'b0 || enc_src !== '0)
         begin bad++; $display("FAIL rmid_outputs got pop=%b push=%b data=%h key=%b src=%0d exp all 0", req_pop, enc_push, enc_data, enc_is_key, enc_src); end
      @(posedge clk); #1;
      reset = 1'b1;
      enc_fifo_full = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (enc_push !== 1'b1 || enc_is_key !== 1'b1 || enc_data !== 32'h38 || enc_src !== 2'd3)
         begin bad++; $display("FAIL rmid_key got push=%b key=%b data=%h src=%0d exp 1 1 00000038 3", enc_push, enc_is_key, enc_data, enc_src); end
      @(negedge clk);
      total++; if (enc_push !== 1'b1 || enc_data !== 32'h1234_5678 || req_pop !== 4'b1000)
         begin bad++; $display("FAIL rmid_val got push=%b data=%h pop=%b exp 1 12345678 1000", enc_push, enc_data, req_pop); end
      @(posedge clk); #1;
      void'(q[3].pop_front());
      drive_inputs();
   endtask

   task automatic test_back_to_back();
      int keys, vals, cyc, last_key, g;
      logic [NUM_REQ-1:0] seen_pop;
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         fld[i] = FIELD_W'($urandom_range(1, 31));
         sgn[i] = 1'($urandom);
         for (int w = 0; w < 3; w++) q[i].push_back($urandom);
      end
      drive_inputs();
      keys = 0; vals = 0; cyc = 0; last_key = 0; g = 0;
      while (vals < 8 && cyc < 60) begin
         @(negedge clk);
         seen_pop = req_pop;
         if (enc_push && enc_is_key) begin
            g = keys % NUM_REQ;
            total++; if (enc_src !== IDX_W'(g) || enc_data !== (32'(fld[g]) << 3))
               begin bad++; $display("FAIL b2b_key n=%0d got src=%0d data=%h exp src=%0d data=%h", keys, enc_src, enc_data, g, 32'(fld[g]) << 3); end
            if (keys > 0) begin
               total++; if (cyc - last_key !== 3)
                  begin bad++; $display("FAIL b2b_spacing n=%0d got=%0d exp=3", keys, cyc - last_key); end
            end
            last_key = cyc;
            keys++;
         end else if (enc_push) begin
            total++; if (enc_data !== model_value(q[g][0], sgn[g]) || req_pop !== NUM_REQ'(1 << g))
               begin bad++; $display("FAIL b2b_val n=%0d got data=%h pop=%b exp data=%h grant=%0d", vals, enc_data, req_pop, model_value(q[g][0], sgn[g]), g); end
            vals++;
         end
         @(posedge clk); #1;
         for (int i = 0; i < NUM_REQ; i++) if (seen_pop[i] && q[i].size() != 0) void'(q[i].pop_front());
         drive_inputs();
         cyc++;
      end
      total++; if (vals !== 8) begin bad++; $display("FAIL b2b_timeout got=%0d exp=8 fields", vals); end
   endtask

   task automatic test_random();
      int n_fields, done, ptr, gr, cyc, g;
      bit pending;
      logic [NUM_REQ-1:0] seen_pop;
      apply_reset();
      n_fields = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         fld[i] = FIELD_W'($urandom_range(0, 31));
         sgn[i] = 1'($urandom);
         for (int w = 0; w < int'($urandom_range(0, 6)); w++) begin
            q[i].push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom);
            n_fields++;
         end
      end
      drive_inputs();
      done = 0; ptr = 0; gr = 0; cyc = 0; pending = 1'b0;
      while (done < n_fields && cyc < 3000) begin
         @(negedge clk);
         seen_pop = req_pop;
         if (enc_fifo_full) begin
            total++; if (enc_push !== 1'b0 || req_pop !== '0)
               begin bad++; $display("FAIL rnd_full cyc=%0d got push=%b pop=%b exp 0 0", cyc, enc_push, req_pop); end
         end
         if (enc_push && enc_is_key) begin
            g = model_pick(ptr);
            total++; if (pending || g < 0 || enc_src !== IDX_W'(g) || enc_data !== (32'(fld[g < 0 ? 0 : g]) << 3))
               begin bad++; $display("FAIL rnd_key cyc=%0d got src=%0d data=%h exp src=%0d pending=%0b", cyc, enc_src, enc_data, g, pending); end
            pending = 1'b1;
            gr = (g < 0) ? 0 : g;
         end else if (enc_push) begin
            total++; if (!pending || enc_src !== IDX_W'(gr) || q[gr].size() == 0 ||
                         enc_data !== model_value(q[gr][0], sgn[gr]) || req_pop !== NUM_REQ'(1 << gr))
               begin bad++; $display("FAIL rnd_val cyc=%0d got src=%0d data=%h pop=%b exp grant=%0d pending=%0b", cyc, enc_src, enc_data, req_pop, gr, pending); end
            pending = 1'b0;
            ptr = (gr + 1) % NUM_REQ;
            done++;
         end else begin
            total++; if (req_pop !== '0)
               begin bad++; $display("FAIL rnd_stray_pop cyc=%0d got=%b exp=0", cyc, req_pop); end
         end
         @(posedge clk); #1;
         for (int i = 0; i < NUM_REQ; i++) if (seen_pop[i] && q[i].size() != 0) void'(q[i].pop_front());
         drive_inputs();
         enc_fifo_full = ($urandom_range(0, 2) == 0);
         cyc++;
      end
      enc_fifo_full = 1'b0;
      total++; if (done !== n_fields) begin bad++; $display("FAIL rnd_timeout got=%0d exp=%0d fields", done, n_fields); end
   endtask

   initial begin
      reset         = 1'b0;
      enc_fifo_full = 1'b0;
      req_empty     = '1;
      req_data      = '0;
      req_field     = '0;
      req_signed    = '0;
      test_reset();
      test_single();
      test_stall();
      test_zigzag();
      test_reset_mid();
      test_back_to_back();
      for (int r = 0; r < 4; r++) test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
